ahb_led_timer_slave: RTL and testbench
======================================

# ahb_led_timer_slave

AHB-Lite slave in FPGA fabric that terminates the MCU hard-core's h2h master port. It decodes h2h address/control, provides a small register bank (control, reload, live count, status, LED output, ID) with a down-counting timer and interrupt flag, and returns read data and responses on h2h_hrdata/h2h_hreadyout/h2h_hresp. It sits directly downstream of the MCU wrapper's h2h bus.

## Interface
- LED_WIDTH, 8, width of led_out (1..32)
- TIMER_WIDTH, 32, width of LOAD/VALUE counters (8..32); upper register bits read 0
- ID_VALUE, 32'hA1B2_0001, read-only ID register content
- h2h_mclk  in  1  bus clock; all state on rising edge
- h2h_rst  in  1  asynchronous, active-high reset
- h2h_hsel  in  1  slave select from fabric decoder
- h2h_hready  in  1  bus-level HREADY (previous transfer complete)
- h2h_haddr  in  32  address; only [4:2] decoded, [1:0] used for byte lanes
- h2h_htrans  in  2  IDLE/BUSY ignored; NONSEQ/SEQ (bit1=1) start a transfer
- h2h_hwrite  in  1  1 = write
- h2h_hsize  in  3  0 byte, 1 half, 2 word; >2 is an error
- h2h_hburst, h2h_hprot  in  3, 4  accepted, ignored
- h2h_hwdata  in  32  write data, valid in data phase
- h2h_hrdata  out  32  read data, valid in data phase
- h2h_hreadyout  out  1  slave ready
- h2h_hresp  out  2  00 OKAY, 01 ERROR
- led_out  out  LED_WIDTH  LED register contents
- timer_irq  out  1  STATUS.expired AND CTRL.irq_en

## Operation
- Address phase accepted when h2h_hsel & h2h_hready & h2h_htrans[1]; latch addr[4:0], hwrite, hsize into data-phase regs. Otherwise data-phase valid cleared.
- Register map (offset = haddr[4:2]*4): 0x00 CTRL RW {irq_en[2], auto_reload[1], enable[0]}; 0x04 LOAD RW; 0x08 VALUE RO (writes ignored, OKAY); 0x0C STATUS {expired[0]}, write-1-to-clear; 0x10 LED RW; 0x14 ID RO; 0x18, 0x1C unmapped.
- Unmapped offset or hsize>2 -> ERROR response; no register changes.
- Writes commit at end of first data-phase cycle using h2h_hwdata and latched byte lanes.
- Writing LOAD also loads VALUE with new LOAD (same commit edge).
- Timer, each cycle with CTRL.enable=1: VALUE!=0 -> VALUE-1; VALUE==0 -> set expired; if auto_reload VALUE<=LOAD else enable<=0.
- Simultaneous: expiry set beats STATUS W1C in same cycle; CPU write to CTRL/LOAD beats timer update of the same field in same cycle.
- State machine: IDLE (hreadyout=1, OKAY) -> ERR1 on erroneous address phase; ERR1 (hreadyout=0, resp=01) -> ERR2; ERR2 (hreadyout=1, resp=01) -> IDLE, or ERR1 again if a new erroneous transfer is accepted; a valid transfer accepted in ERR2 goes to IDLE.

## Timing
- Reads and valid writes: zero wait states; h2h_hrdata combinational from latched offset and registers in data phase, 0 outside read data phase.
- ERROR: exactly two data-phase cycles (ERR1, ERR2).
- timer_irq registered-state derived, asserts cycle after VALUE reaches 0 while enabled.
- Reset (async, any time incl. mid-transfer): state IDLE, h2h_hreadyout=1, h2h_hresp=00, h2h_hrdata=0, CTRL=0, LOAD=0, VALUE=0, STATUS=0, led_out=0, timer_irq=0; in-flight transfer discarded.

## Configuration
- AHB_LED_TIMER_BYTE_WR_EN defined: hsize 0/1 writes update only addressed byte/halfword lanes (haddr[1:0]); sub-word reads return full word.
- Not defined: any write with hsize<2 -> ERROR response, no update; sub-word reads still OKAY.

## Test plan
- Reset release, read 0x14 -> hrdata=32'hA1B2_0001, OKAY, hreadyout=1 throughout; led_out=0.
- Write LED=0xA5, read back -> led_out=8'hA5 cycle after write data phase, read=0x000000A5.
- LOAD=3, CTRL=0b101 -> VALUE 3,2,1,0, expired=1, timer_irq=1, enable clears; write STATUS=1 -> timer_irq=0.
- LOAD=2, CTRL=0b011 -> VALUE reloads 2 after 0 repeatedly; W1C in same cycle as expiry -> expired remains 1.
- Read offset 0x18 -> hreadyout 0 then 1 with hresp=01 both cycles; back-to-back valid read next -> OKAY.
- Byte write 0xFF to 0x11 -> with macro LED bits[15:8] only (LED_WIDTH=16), without macro ERROR and LED unchanged.

Source files
------------

// File: rtl/ahb_led_timer_slave.sv
// ahb_led_timer_slave: AHB-Lite LED/timer register slave; define AHB_LED_TIMER_BYTE_WR_EN to allow byte/halfword writes
module ahb_led_timer_slave #(
  parameter int          LED_WIDTH   = 8,
  parameter int          TIMER_WIDTH = 32,
  parameter logic [31:0] ID_VALUE    = 32'hA1B2_0001
) (
  input  logic                 h2h_mclk,
  input  logic                 h2h_rst,
  input  logic                 h2h_hsel,
  input  logic                 h2h_hready,
  input  logic [31:0]          h2h_haddr,
  input  logic [1:0]           h2h_htrans,
  input  logic                 h2h_hwrite,
  input  logic [2:0]           h2h_hsize,
  input  logic [2:0]           h2h_hburst,
  input  logic [3:0]           h2h_hprot,
  input  logic [31:0]          h2h_hwdata,
  output logic [31:0]          h2h_hrdata,
  output logic                 h2h_hreadyout,
  output logic [1:0]           h2h_hresp,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 timer_irq
);
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
  state_t                 state_q, state_d;
  logic                   dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
  logic [4:0]             dp_addr_q, dp_addr_d;
  logic [2:0]             dp_size_q, dp_size_d;
  logic [2:0]             ctrl_q, ctrl_d;
  logic [TIMER_WIDTH-1:0] load_q, load_d, value_q, value_d;
  logic                   expired_q, expired_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;
  logic                   acc, err_a, wr, hit;
  logic [2:0]             idx;
  logic [31:0]            rd_word, wmask, wdata;
  logic                   unused;
  assign unused = ^{h2h_hburst, h2h_hprot, h2h_haddr[31:5], dp_size_q, dp_addr_q[1:0]};
  always_comb begin
    acc = h2h_hsel & h2h_hready & h2h_htrans[1];
    err_a = (h2h_haddr[4:3] == 2'b11) | (h2h_hsize > 3'd2)
`ifndef AHB_LED_TIMER_BYTE_WR_EN
      | (h2h_hwrite & (h2h_hsize < 3'd2))
`endif
      ;
    state_d = (acc & err_a) ? ERR1 : (state_q == ERR1) ? ERR2 : IDLE;
    dp_valid_d = acc & ~err_a;
    dp_addr_d = acc ? h2h_haddr[4:0] : dp_addr_q;
    dp_write_d = acc ? h2h_hwrite : dp_write_q;
    dp_size_d = acc ? h2h_hsize : dp_size_q;
  end
  always_comb begin
    idx = dp_addr_q[4:2];
    case (idx)
      3'd0:    rd_word = {29'd0, ctrl_q};
      3'd1:    rd_word = 32'(load_q);
      3'd2:    rd_word = 32'(value_q);
      3'd3:    rd_word = {31'd0, expired_q};
      3'd4:    rd_word = 32'(led_q);
      3'd5:    rd_word = ID_VALUE;
      default: rd_word = '0;
    endcase
  end
  always_comb begin
`ifdef AHB_LED_TIMER_BYTE_WR_EN
    wmask = (dp_size_q == 3'd0) ? 32'hFF << {dp_addr_q[1:0], 3'b000} :
            (dp_size_q == 3'd1) ? 32'hFFFF << {dp_addr_q[1], 4'b0000} : '1;
`else
    wmask = '1;
`endif
    wdata = (rd_word & ~wmask) | (h2h_hwdata & wmask);
    wr = dp_valid_q & dp_write_q;
    hit = ctrl_q[0] & (value_q == '0);
    value_d = ~ctrl_q[0] ? value_q : ~hit ? value_q - TIMER_WIDTH'(1) : ctrl_q[1] ? load_q : value_q;
    ctrl_d = (hit & ~ctrl_q[1]) ? {ctrl_q[2:1], 1'b0} : ctrl_q;
    // a fresh expiry wins over a same-cycle write-1-to-clear
    expired_d = hit | (expired_q & ~(wr & (idx == 3'd3) & wmask[0] & h2h_hwdata[0]));
    load_d = load_q;
    led_d = led_q;
    if (wr & (idx == 3'd0)) ctrl_d = wdata[2:0];
    if (wr & (idx == 3'd1)) begin
      load_d = wdata[TIMER_WIDTH-1:0];
      value_d = wdata[TIMER_WIDTH-1:0];
    end
    if (wr & (idx == 3'd4)) led_d = wdata[LED_WIDTH-1:0];
  end
  always_ff @(posedge h2h_mclk or posedge h2h_rst) begin
    if (h2h_rst) begin
      state_q <= IDLE;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q <= '0;
      dp_size_q <= '0;
      ctrl_q <= '0;
      load_q <= '0;
      value_q <= '0;
      expired_q <= 1'b0;
      led_q <= '0;
    end else begin
      state_q <= state_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q <= dp_addr_d;
      dp_size_q <= dp_size_d;
      ctrl_q <= ctrl_d;
      load_q <= load_d;
      value_q <= value_d;
      expired_q <= expired_d;
      led_q <= led_d;
    end
  end
  assign h2h_hrdata = (dp_valid_q & ~dp_write_q) ? rd_word : '0;
  assign h2h_hreadyout = state_q != ERR1;
  assign h2h_hresp = {1'b0, state_q != IDLE};
  assign led_out = led_q;
  assign timer_irq = expired_q & ctrl_q[2];
endmodule

// File: tb/tb_ahb_led_timer_slave.sv
// tb_ahb_led_timer_slave: directed and randomized AHB traffic against a behavioural register/timer model
module tb_ahb_led_timer_slave;
  localparam int LW = 16;
  localparam logic [31:0] ID = 32'hA1B2_0001;
`ifdef AHB_LED_TIMER_BYTE_WR_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic h2h_hsel = 1'b0, h2h_hwrite = 1'b0, h2h_hready;
  logic [31:0] h2h_haddr = '0, h2h_hwdata = '0, h2h_hrdata;
  logic [1:0] h2h_htrans = '0, h2h_hresp;
  logic [2:0] h2h_hsize = 3'd2, h2h_hburst = '0;
  logic [3:0] h2h_hprot = '0;
  logic h2h_hreadyout, timer_irq;
  logic [LW-1:0] led_out;
  int n_cmp = 0, n_fail = 0;
  bit started = 1'b0;
  assign h2h_hready = h2h_hreadyout;
  ahb_led_timer_slave #(.LED_WIDTH(LW), .TIMER_WIDTH(32), .ID_VALUE(ID)) dut (
    .h2h_mclk(clk), .h2h_rst(rst), .h2h_hsel(h2h_hsel), .h2h_hready(h2h_hready),
    .h2h_haddr(h2h_haddr), .h2h_htrans(h2h_htrans), .h2h_hwrite(h2h_hwrite),
    .h2h_hsize(h2h_hsize), .h2h_hburst(h2h_hburst), .h2h_hprot(h2h_hprot),
    .h2h_hwdata(h2h_hwdata), .h2h_hrdata(h2h_hrdata), .h2h_hreadyout(h2h_hreadyout),
    .h2h_hresp(h2h_hresp), .led_out(led_out), .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;
  // Model state: registers as plain values, error response as a countdown of remaining error cycles
  logic [2:0] m_ctrl = '0;
  logic [31:0] m_load = '0, m_value = '0;
  logic m_exp = 1'b0;
  logic [LW-1:0] m_led = '0;
  int m_err = 0;
  logic m_pv = 1'b0, m_pw = 1'b0;
  logic [4:0] m_pa = '0;
  logic [2:0] m_ps = '0;
  function automatic logic [31:0] m_read(input logic [2:0] i);
    case (i)
      3'd0: return {29'd0, m_ctrl};
      3'd1: return m_load;
      3'd2: return m_value;
      3'd3: return {31'd0, m_exp};
      3'd4: return 32'(m_led);
      3'd5: return ID;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] lane_mask(input logic [2:0] s, input logic [1:0] a);
    if (BYTE_EN && s == 3'd0) return 32'hFF << (8 * a);
    if (BYTE_EN && s == 3'd1) return 32'hFFFF << (16 * a[1]);
    return 32'hFFFF_FFFF;
  endfunction
  always @(posedge clk or posedge rst) begin : model
    logic [31:0] mk, wv, n_value, n_load;
    logic [2:0] n_ctrl;
    logic [LW-1:0] n_led;
    logic n_exp, acc, bad, hit;
    if (rst) begin
      m_ctrl <= '0; m_load <= '0; m_value <= '0; m_exp <= 1'b0; m_led <= '0;
      m_err <= 0; m_pv <= 1'b0;
    end else begin
      n_ctrl = m_ctrl; n_value = m_value; n_load = m_load; n_exp = m_exp; n_led = m_led;
      hit = m_ctrl[0] && m_value == 0;
      if (m_ctrl[0]) begin
        if (m_value != 0) n_value = m_value - 32'd1;
        else begin
          n_exp = 1'b1;
          if (m_ctrl[1]) n_value = m_load;
          else n_ctrl[0] = 1'b0;
        end
      end
      if (m_pv && m_pw) begin
        mk = lane_mask(m_ps, m_pa[1:0]);
        wv = (m_read(m_pa[4:2]) & ~mk) | (h2h_hwdata & mk);
        case (m_pa[4:2])
          3'd0: n_ctrl = wv[2:0];
          3'd1: begin n_load = wv; n_value = wv; end
          3'd3: if (h2h_hwdata[0] && mk[0] && !hit) n_exp = 1'b0;
          3'd4: n_led = wv[LW-1:0];
          default: ;
        endcase
      end
      acc = h2h_hsel && h2h_htrans[1] && m_err != 2;
      bad = acc && (h2h_haddr[4:2] >= 3'd6 || h2h_hsize > 3'd2 || (!BYTE_EN && h2h_hwrite && h2h_hsize < 3'd2));
      m_err <= bad ? 2 : (m_err == 2 ? 1 : 0);
      m_pv <= acc && !bad;
      m_pa <= h2h_haddr[4:0];
      m_pw <= h2h_hwrite;
      m_ps <= h2h_hsize;
      m_ctrl <= n_ctrl; m_value <= n_value; m_load <= n_load; m_exp <= n_exp; m_led <= n_led;
    end
  end
  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if (h2h_hrdata !== ((m_pv && !m_pw) ? m_read(m_pa[4:2]) : 32'd0) ||
          h2h_hreadyout !== (m_err != 2) || h2h_hresp !== {1'b0, m_err != 0} ||
          led_out !== m_led || timer_irq !== (m_exp & m_ctrl[2])) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t: rdata %h want %h, rdy %b want %b, resp %b want %b, led %h want %h, irq %b want %b",
                 $time, h2h_hrdata, (m_pv && !m_pw) ? m_read(m_pa[4:2]) : 32'd0, h2h_hreadyout, m_err != 2,
                 h2h_hresp, {1'b0, m_err != 0}, led_out, m_led, timer_irq, m_exp & m_ctrl[2]);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] wd);
    int k = 0;
    h2h_hsel = 1'b1; h2h_haddr = a; h2h_htrans = 2'b10; h2h_hwrite = w; h2h_hsize = s;
    h2h_hburst = 3'($urandom); h2h_hprot = 4'($urandom);
    while (!h2h_hreadyout && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    chk("xfer_ready_bound", {31'd0, h2h_hreadyout}, 32'd1);
    @(posedge clk); #1;
    h2h_hsel = 1'b0; h2h_htrans = 2'b00;
    if (w) h2h_hwdata = wd;
  endtask
  task automatic rand_xfer();
    logic [2:0] i, s;
    logic [1:0] lo;
    logic [31:0] d;
    int r;
    r = $urandom_range(0, 15);
    i = r < 14 ? 3'(r % 6) : 3'(r - 8);
    r = $urandom_range(0, 7);
    s = r < 5 ? 3'd2 : r == 5 ? 3'd0 : r == 6 ? 3'd1 : 3'($urandom_range(3, 7));
    lo = s == 3'd0 ? 2'($urandom_range(0, 3)) : s == 3'd1 ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
    d = $urandom;
    if (i == 3'd0) d = $urandom_range(0, 7);
    else if (i == 3'd1) d = $urandom_range(0, 6);
    else if (i == 3'd3) d = $urandom_range(0, 1);
    if (s < 3'd2) d = {4{d[7:0]}};
    xfer({27'($urandom), i, lo}, 1'($urandom_range(0, 1)), s, d);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    #2 rst = 1'b1;
    #1 started = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, h2h_hreadyout}, 32'd1);
    chk("rst_resp", {30'd0, h2h_hresp}, 32'd0);
    chk("rst_rdata", h2h_hrdata, 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    xfer(32'h14, 1'b0, 3'd2, 32'd0);
    @(negedge clk);
    chk("id_read", h2h_hrdata, 32'hA1B2_0001);
    chk("id_resp", {30'd0, h2h_hresp}, 32'd0);
    xfer(32'h10, 1'b1, 3'd2, 32'hA5);
    @(negedge clk);
    chk("led_before_commit", 32'(led_out), 32'd0);
    @(negedge clk);
    chk("led_after_commit", 32'(led_out), 32'hA5);
    xfer(32'h10, 1'b0, 3'd2, 32'd0);
    @(negedge clk);
    chk("led_readback", h2h_hrdata, 32'hA5);
    xfer(32'h04, 1'b1, 3'd2, 32'd3);
    xfer(32'h00, 1'b1, 3'd2, 32'd5);
    for (int v = 3; v >= 0; v--) begin
      xfer(32'h08, 1'b0, 3'd2, 32'd0);
      @(negedge clk);
      chk("oneshot_value", h2h_hrdata, 32'(v));
    end
    xfer(32'h0C, 1'b0, 3'd2, 32'd0);
    @(negedge clk);
    chk("oneshot_expired", h2h_hrdata, 32'd1);
    chk("oneshot_irq", {31'd0, timer_irq}, 32'd1);
    xfer(32'h00, 1'b0, 3'd2, 32'd0);
    @(negedge clk);
    chk("oneshot_enable_cleared", h2h_hrdata, 32'd4);
    xfer(32'h0C, 1'b1, 3'd2, 32'd1);
    @(negedge clk);
    chk("w1c_irq_before", {31'd0, timer_irq}, 32'd1);
    @(negedge clk);
    chk("w1c_irq_after", {31'd0, timer_irq}, 32'd0);
    xfer(32'h04, 1'b1, 3'd2, 32'd2);
    xfer(32'h00, 1'b1, 3'd2, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    xfer(32'h0C, 1'b1, 3'd2, 32'd1);
    @(negedge clk);
    chk("reload_first_expiry", {31'd0, timer_irq}, 32'd1);
    @(negedge clk);
    chk("reload_cleared", {31'd0, timer_irq}, 32'd0);
    xfer(32'h0C, 1'b1, 3'd2, 32'd1);
    @(negedge clk);
    chk("reload_pre_collision", {31'd0, timer_irq}, 32'd0);
    xfer(32'h0C, 1'b0, 3'd2, 32'd0);
    @(negedge clk);
    chk("set_beats_w1c", h2h_hrdata, 32'd1);
    chk("set_beats_w1c_irq", {31'd0, timer_irq}, 32'd1);
    xfer(32'h08, 1'b0, 3'd2, 32'd0);
    @(negedge clk);
    chk("reload_value", h2h_hrdata, 32'd1);
    xfer(32'h00, 1'b1, 3'd2, 32'd0);
    xfer(32'h18, 1'b0, 3'd2, 32'd0);
    @(negedge clk);
    chk("err1_ready", {31'd0, h2h_hreadyout}, 32'd0);
    chk("err1_resp", {30'd0, h2h_hresp}, 32'd1);
    @(negedge clk);
    chk("err2_ready", {31'd0, h2h_hreadyout}, 32'd1);
    chk("err2_resp", {30'd0, h2h_hresp}, 32'd1);
    xfer(32'h14, 1'b0, 3'd2, 32'd0);
    @(negedge clk);
    chk("after_err_resp", {30'd0, h2h_hresp}, 32'd0);
    chk("after_err_rdata", h2h_hrdata, ID);
    xfer(32'h11, 1'b1, 3'd0, 32'h0000_FF00);
    @(negedge clk);
    chk("byte_wr_resp", {30'd0, h2h_hresp}, BYTE_EN ? 32'd0 : 32'd1);
    @(negedge clk);
    chk("byte_wr_led", 32'(led_out), BYTE_EN ? 32'hFFA5 : 32'h00A5);
    xfer(32'h12, 1'b0, 3'd1, 32'd0);
    @(negedge clk);
    chk("half_read_resp", {30'd0, h2h_hresp}, 32'd0);
    chk("half_read_rdata", h2h_hrdata, BYTE_EN ? 32'hFFA5 : 32'h00A5);
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (n == 400) begin
        @(posedge clk); #3;
        rst = 1'b1; h2h_hsel = 1'b0; h2h_htrans = 2'b00;
        @(negedge clk); @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
      end else if (r < 6) rand_xfer();
      else if (r < 8) begin
        @(posedge clk); #1;
      end else begin
        h2h_hsel = 1'($urandom_range(0, 1));
        h2h_htrans = h2h_hsel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        h2h_haddr = $urandom; h2h_hwrite = 1'($urandom_range(0, 1)); h2h_hsize = 3'($urandom);
        @(posedge clk); #1;
        h2h_hsel = 1'b0; h2h_htrans = 2'b00;
      end
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
